// File: rtl/ntt_ctrl_pkg.sv
// Shared types and helpers for the NTT butterfly sequencer: FSM state encoding,
// default loop dimensions and the stage-to-butterfly-span function.
package ntt_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int LOG_N_DEF = 5;
  localparam int NUM_BF    = 2 ** (LOG_N_DEF - 1);
  localparam int IDX_W     = 4;

  // Butterfly span m: forward stages shrink it from N/2 down to 1,
  // inverse stages grow it from 1 up to N/2.
  function automatic int calc_m(input logic [IDX_W-1:0] s, input logic fwd, input int log_n);
    int sh;
    sh = fwd ? (log_n - 1 - int'(s)) : int'(s);
    return 1 << sh;
  endfunction

endpackage

// File: rtl/bf_write_delay.sv
// Write-back delay line: carries each issued butterfly's address pair through
// the butterfly pipeline and turns it into a one-hot-pair write enable.
module bf_write_delay #(
  parameter int AW    = 5,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  input  logic [AW-1:0]   i_addr1,
  input  logic [AW-1:0]   i_addr2,
  output logic [AW-1:0]   o_waddr1,
  output logic [AW-1:0]   o_waddr2,
  output logic [2**AW-1:0] o_we
);

  localparam int NE = 2 ** AW;

  logic          r_vld [DEPTH];
  logic [AW-1:0] r_a1  [DEPTH];
  logic [AW-1:0] r_a2  [DEPTH];
  logic [NE-1:0] w_one;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_vld[i] <= 1'b0;
        r_a1[i]  <= '0;
        r_a2[i]  <= '0;
      end
    end else begin
      r_vld[0] <= i_valid;
      r_a1[0]  <= i_addr1;
      r_a2[0]  <= i_addr2;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_a1[i]  <= r_a1[i-1];
        r_a2[i]  <= r_a2[i-1];
      end
    end
  end

  assign w_one    = NE'(1);
  assign o_waddr1 = r_a1[DEPTH-1];
  assign o_waddr2 = r_a2[DEPTH-1];
  assign o_we     = r_vld[DEPTH-1] ? ((w_one << r_a1[DEPTH-1]) | (w_one << r_a2[DEPTH-1])) : '0;

endmodule

// File: rtl/ntt_loop_sequencer.sv
// Stage/butterfly sequencer for the NTT unit plus the arbiter that lends the
// butterfly to single-operation core requests while no transform is running.
//
// state | meaning
// IDLE  | waiting for start; butterfly available to the core
// SETUP | one cycle, tell the omega unit a new stage begins
// ISSUE | one butterfly per cycle, k = 0..NUM_BF-1
// DRAIN | BF_LAT cycles, let the stage's writes land before the next reads
// DONE  | one-cycle done pulse
module ntt_loop_sequencer
  import ntt_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int LOG_N      = 5,
  parameter int BF_LAT     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         fwd_ntt,
  input  logic                         core_req,
  output logic                         core_gnt,
  output logic                         busy,
  output logic                         done,
  output logic [ADDR_WIDTH-2:0]        raddr1,
  output logic [ADDR_WIDTH-2:0]        raddr2,
  output logic [ADDR_WIDTH-2:0]        waddr1,
  output logic [ADDR_WIDTH-2:0]        waddr2,
  output logic [2**(ADDR_WIDTH-1)-1:0] we,
  output logic                         update_m,
  output logic [IDX_W-1:0]             index,
  output logic                         update_omega
);

  localparam int AW  = ADDR_WIDTH - 1;
  localparam int NBF = 2 ** (LOG_N - 1);
  localparam int KW  = $clog2(NBF);
  localparam int DW  = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

  state_t           r_state;
  state_t           w_next;
  logic             r_fwd;
  logic [IDX_W-1:0] r_s;
  logic [KW-1:0]    r_k;
  logic [DW-1:0]    r_drain;

  logic             w_last_bf;
  logic             w_drain_tc;
  logic             w_last_stage;
  logic             w_issue;
  logic [AW-1:0]    w_m;
  logic [AW-1:0]    w_mask;
  logic [AW-1:0]    w_k;
  logic [AW-1:0]    w_j;
  logic [AW-1:0]    w_base;
  logic [AW-1:0]    w_r1;
  logic [AW-1:0]    w_r2;

  assign w_last_bf    = (r_k == KW'(NBF - 1));
  assign w_drain_tc   = (r_drain == '0);
  assign w_last_stage = (r_s == IDX_W'(LOG_N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SETUP;
      SETUP:   w_next = ISSUE;
      ISSUE:   if (w_last_bf) w_next = DRAIN;
      DRAIN:   if (w_drain_tc) w_next = w_last_stage ? DONE : SETUP;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd   <= 1'b0;
      r_s     <= '0;
      r_k     <= '0;
      r_drain <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_fwd <= fwd_ntt;
            r_s   <= '0;
            r_k   <= '0;
          end
        end
        ISSUE: begin
          r_k <= r_k + 1'b1;
          if (w_last_bf) r_drain <= DW'(BF_LAT - 1);
        end
        DRAIN: begin
          if (w_drain_tc) begin
            if (!w_last_stage) r_s <= r_s + 1'b1;
          end else begin
            r_drain <= r_drain - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // m is a power of two, so k mod m and 2*m*(k/m) reduce to masking and a shift.
  assign w_m    = AW'(calc_m(r_s, r_fwd, LOG_N));
  assign w_mask = w_m - 1'b1;
  assign w_k    = AW'(r_k);
  assign w_j    = w_k & w_mask;
  assign w_base = (w_k & ~w_mask) << 1;
  assign w_r1   = w_base | w_j;
  assign w_r2   = w_r1 + w_m;

  always_comb begin
    busy         = (r_state != IDLE);
    index        = r_s;
    core_gnt     = rst_n & core_req & ~start & (r_state == IDLE);
    done         = 1'b0;
    update_m     = 1'b0;
    update_omega = 1'b0;
    raddr1       = '0;
    raddr2       = '0;
    w_issue      = 1'b0;
    case (r_state)
      SETUP: update_m = 1'b1;
      ISSUE: begin
        w_issue      = 1'b1;
        raddr1       = w_r1;
        raddr2       = w_r2;
        update_omega = (w_j == '0) && (r_k != '0);
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  bf_write_delay #(
    .AW    (AW),
    .DEPTH (BF_LAT)
  ) u_wdly (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (w_issue),
    .i_addr1  (raddr1),
    .i_addr2  (raddr2),
    .o_waddr1 (waddr1),
    .o_waddr2 (waddr2),
    .o_we     (we)
  );

endmodule

// File: tb/tb_ntt_loop_sequencer.sv
// Directed bench for ntt_loop_sequencer: default build (BF_LAT=2) plus a
// BF_LAT=4 instance, checked against a cycle model built from the loop formulas.
module tb_ntt_loop_sequencer;

  localparam int MAXC = 112;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start4 = 1'b0;
  logic fwd_ntt = 1'b0;
  logic core_req = 1'b0;

  logic        core_gnt, busy, done, update_m, update_omega;
  logic [4:0]  raddr1, raddr2, waddr1, waddr2;
  logic [31:0] we;
  logic [3:0]  index;

  logic        core_gnt4, busy4, done4, update_m4, update_omega4;
  logic [4:0]  raddr1_4, raddr2_4, waddr1_4, waddr2_4;
  logic [31:0] we4;
  logic [3:0]  index4;

  ntt_loop_sequencer #(.ADDR_WIDTH(6), .LOG_N(5), .BF_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fwd_ntt(fwd_ntt), .core_req(core_req),
    .core_gnt(core_gnt), .busy(busy), .done(done), .raddr1(raddr1), .raddr2(raddr2),
    .waddr1(waddr1), .waddr2(waddr2), .we(we), .update_m(update_m), .index(index),
    .update_omega(update_omega));

  ntt_loop_sequencer #(.ADDR_WIDTH(6), .LOG_N(5), .BF_LAT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .fwd_ntt(fwd_ntt), .core_req(core_req),
    .core_gnt(core_gnt4), .busy(busy4), .done(done4), .raddr1(raddr1_4), .raddr2(raddr2_4),
    .waddr1(waddr1_4), .waddr2(waddr2_4), .we(we4), .update_m(update_m4), .index(index4),
    .update_omega(update_omega4));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [4:0]  rr1 [2][MAXC];
  logic [4:0]  rr2 [2][MAXC];
  logic [4:0]  rwa1[2][MAXC];
  logic [4:0]  rwa2[2][MAXC];
  logic [31:0] rwe [2][MAXC];
  logic [3:0]  ridx[2][MAXC];
  logic        rum [2][MAXC];
  logic        ruo [2][MAXC];
  logic        rdone[2][MAXC];
  logic        rbusy[2][MAXC];
  logic        rgnt[2][MAXC];

  typedef struct {
    logic st;
    logic req;
    logic rn;
    logic e_gnt;
    logic e_busy;
  } cvec_t;

  typedef struct {
    logic fwd;
    int   s;
    int   k;
    int   r1;
    int   r2;
    logic uo;
  } avec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic void pair(input logic fwd, input int s, input int k,
                               output int a1, output int a2, output int j);
    int m, g;
    m  = fwd ? (1 << (4 - s)) : (1 << s);
    j  = k % m;
    g  = k / m;
    a1 = 2 * m * g + j;
    a2 = a1 + m;
  endfunction

  function automatic void model(input int per, input int c,
                                output logic iss, output int s, output int k);
    iss = 1'b0;
    s   = 0;
    k   = 0;
    if (c >= 1 && c <= 5 * per) begin
      s   = (c - 1) / per;
      k   = (c - 1) % per - 1;
      iss = (k >= 0 && k < 16);
    end
  endfunction

  function automatic logic [63:0] all_out();
    return 64'({core_gnt, busy, done, raddr1, raddr2, waddr1, waddr2, we, update_m, index, update_omega});
  endfunction

  task automatic run(input logic fwd, input logic with4, input int req_cyc, input logic req_at_start);
    @(negedge clk);
    fwd_ntt = fwd;
    start   = 1'b1;
    start4  = with4;
    if (req_at_start) core_req = 1'b1;
    #1;
    if (req_at_start) chk("gnt_with_start", 64'(core_gnt), 64'd0);
    for (int c = 1; c < MAXC; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start  = 1'b0;
        start4 = 1'b0;
        if (req_at_start) core_req = 1'b0;
      end
      if (req_cyc != 0 && c == req_cyc) core_req = 1'b1;
      #1;
      rr1[0][c] = raddr1;   rr2[0][c] = raddr2;   rwa1[0][c] = waddr1;   rwa2[0][c] = waddr2;
      rwe[0][c] = we;       ridx[0][c] = index;   rum[0][c] = update_m;  ruo[0][c] = update_omega;
      rdone[0][c] = done;   rbusy[0][c] = busy;   rgnt[0][c] = core_gnt;
      rr1[1][c] = raddr1_4; rr2[1][c] = raddr2_4; rwa1[1][c] = waddr1_4; rwa2[1][c] = waddr2_4;
      rwe[1][c] = we4;      ridx[1][c] = index4;  rum[1][c] = update_m4; ruo[1][c] = update_omega4;
      rdone[1][c] = done4;  rbusy[1][c] = busy4;  rgnt[1][c] = core_gnt4;
    end
    core_req = 1'b0;
  endtask

  task automatic check_run(input int sel, input logic fwd, input int lat, input string tag);
    int per, dexp, dfirst, ndone, bad_addr, bad_we, bad_um, bad_uo, bad_busy, uo_s0, uo_s4;
    per = 17 + lat;
    dexp = 5 * per + 1;
    dfirst = -1;
    ndone = 0; bad_addr = 0; bad_we = 0; bad_um = 0; bad_uo = 0; bad_busy = 0;
    uo_s0 = 0; uo_s4 = 0;
    for (int c = 1; c < MAXC; c++) begin
      logic iss, iss2, euo, eum;
      int s, k, s2, k2, a1, a2, j, e1, e2, eidx;
      logic [31:0] ewe;
      model(per, c, iss, s, k);
      e1 = 0; e2 = 0; euo = 1'b0;
      if (iss) begin
        pair(fwd, s, k, a1, a2, j);
        e1 = a1; e2 = a2;
        euo = (j == 0 && k != 0);
      end
      if (rr1[sel][c] !== 5'(e1) || rr2[sel][c] !== 5'(e2)) bad_addr++;
      if (ruo[sel][c] !== euo) bad_uo++;
      if (iss && ruo[sel][c] === 1'b1 && s == 0) uo_s0++;
      if (iss && ruo[sel][c] === 1'b1 && s == 4) uo_s4++;
      eum  = (c <= 5 * per) && ((c - 1) % per == 0);
      eidx = (c <= 5 * per) ? s : 4;
      if (rum[sel][c] !== eum || ridx[sel][c] !== 4'(eidx)) bad_um++;
      ewe = '0;
      if (c - lat >= 1) begin
        model(per, c - lat, iss2, s2, k2);
        if (iss2) begin
          pair(fwd, s2, k2, a1, a2, j);
          ewe = (32'd1 << a1) | (32'd1 << a2);
          if (rwa1[sel][c] !== 5'(a1) || rwa2[sel][c] !== 5'(a2)) bad_we++;
        end
      end
      if (rwe[sel][c] !== ewe) bad_we++;
      if (rbusy[sel][c] !== (c <= dexp)) bad_busy++;
      if (rdone[sel][c] === 1'b1) begin
        ndone++;
        if (dfirst < 0) dfirst = c;
      end
    end
    chk({tag, "_done_cycle"}, 64'(dfirst), 64'(dexp));
    chk({tag, "_done_pulses"}, 64'(ndone), 64'd1);
    chk({tag, "_read_addr_errs"}, 64'(bad_addr), 64'd0);
    chk({tag, "_write_errs"}, 64'(bad_we), 64'd0);
    chk({tag, "_update_m_index_errs"}, 64'(bad_um), 64'd0);
    chk({tag, "_update_omega_errs"}, 64'(bad_uo), 64'd0);
    chk({tag, "_busy_errs"}, 64'(bad_busy), 64'd0);
    chk({tag, "_omega_stage0"}, 64'(uo_s0), fwd ? 64'd0 : 64'd15);
    chk({tag, "_omega_stage4"}, 64'(uo_s4), fwd ? 64'd15 : 64'd0);
  endtask

  task automatic check_table(input logic fwd, input avec_t tab[16]);
    for (int i = 0; i < 16; i++) begin
      int c;
      logic [63:0] act, exp;
      if (tab[i].fwd == fwd) begin
        c = 2 + tab[i].s * 19 + tab[i].k;
        act = 64'({rr1[0][c], rr2[0][c], ruo[0][c], rwe[0][c+2]});
        exp = 64'({5'(tab[i].r1), 5'(tab[i].r2), tab[i].uo,
                   (32'd1 << tab[i].r1) | (32'd1 << tab[i].r2)});
        chk($sformatf("addr_f%0d_s%0d_k%0d", fwd, tab[i].s, tab[i].k), act, exp);
      end
    end
  endtask

  initial begin
    cvec_t cv[5];
    avec_t av[16];
    int bad, su;

    cv[0] = '{st: 1'b0, req: 1'b0, rn: 1'b1, e_gnt: 1'b0, e_busy: 1'b0};
    cv[1] = '{st: 1'b0, req: 1'b1, rn: 1'b1, e_gnt: 1'b1, e_busy: 1'b0};
    cv[2] = '{st: 1'b1, req: 1'b1, rn: 1'b1, e_gnt: 1'b0, e_busy: 1'b0};
    cv[3] = '{st: 1'b1, req: 1'b0, rn: 1'b1, e_gnt: 1'b0, e_busy: 1'b0};
    cv[4] = '{st: 1'b0, req: 1'b1, rn: 1'b0, e_gnt: 1'b0, e_busy: 1'b0};

    av[0]  = '{1'b1, 0, 0,  0, 16, 1'b0};
    av[1]  = '{1'b1, 0, 15, 15, 31, 1'b0};
    av[2]  = '{1'b1, 1, 9,  17, 25, 1'b0};
    av[3]  = '{1'b1, 1, 8,  16, 24, 1'b1};
    av[4]  = '{1'b1, 2, 5,  9,  13, 1'b0};
    av[5]  = '{1'b1, 3, 6,  12, 14, 1'b1};
    av[6]  = '{1'b1, 4, 0,  0,  1,  1'b0};
    av[7]  = '{1'b1, 4, 7,  14, 15, 1'b1};
    av[8]  = '{1'b1, 4, 15, 30, 31, 1'b1};
    av[9]  = '{1'b0, 0, 3,  6,  7,  1'b1};
    av[10] = '{1'b0, 0, 0,  0,  1,  1'b0};
    av[11] = '{1'b0, 2, 6,  10, 14, 1'b0};
    av[12] = '{1'b0, 3, 9,  17, 25, 1'b0};
    av[13] = '{1'b0, 4, 0,  0,  16, 1'b0};
    av[14] = '{1'b0, 4, 15, 15, 31, 1'b0};
    av[15] = '{1'b0, 1, 3,  5,  7,  1'b0};

    repeat (3) @(negedge clk);
    #1 chk("in_reset_zero", all_out(), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1 chk($sformatf("idle_zero_c%0d", i), all_out(), 64'd0);
    end

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = cv[i].st; core_req = cv[i].req; rst_n = cv[i].rn;
      #1 chk($sformatf("arb_vec%0d", i), 64'({core_gnt, busy, we}),
             64'({cv[i].e_gnt, cv[i].e_busy, 32'd0}));
      #1 start = 1'b0; core_req = 1'b0; rst_n = 1'b1;
    end

    run(1'b1, 1'b1, 5, 1'b0);
    check_run(0, 1'b1, 2, "fwd");
    check_table(1'b1, av);
    bad = 0;
    for (int c = 5; c <= 96; c++) if (rgnt[0][c] !== 1'b0) bad++;
    chk("gnt_blocked_while_busy", 64'(bad), 64'd0);
    chk("gnt_after_done", 64'(rgnt[0][97]), 64'd1);
    check_run(1, 1'b1, 4, "fwd_lat4");
    bad = 0;
    for (int s = 1; s <= 4; s++) begin
      su = -1;
      for (int c = 1; c < MAXC; c++)
        if (su < 0 && rum[1][c] === 1'b1 && ridx[1][c] === 4'(s)) su = c;
      if (su < 0) bad++;
      else for (int c = su + 1; c <= su + 4; c++) if (rwe[1][c] !== 32'd0) bad++;
    end
    chk("lat4_stage_order_errs", 64'(bad), 64'd0);

    run(1'b0, 1'b0, 0, 1'b1);
    check_run(0, 1'b0, 2, "inv");
    check_table(1'b0, av);

    @(negedge clk);
    fwd_ntt = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 44; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    #1 chk("busy_before_reset", 64'({busy, index}), 64'({1'b1, 4'd2}));
    core_req = 1'b1;
    rst_n = 1'b0;
    #1 chk("mid_reset_zero", all_out(), 64'd0);
    @(negedge clk);
    #1 chk("mid_reset_held_zero", all_out(), 64'd0);
    rst_n = 1'b1;
    core_req = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 if (we !== 32'd0 || busy !== 1'b0) bad++;
    end
    chk("no_write_after_reset", 64'(bad), 64'd0);
    run(1'b1, 1'b0, 0, 1'b0);
    check_run(0, 1'b1, 2, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
